// File: rtl/beam_sum_if.sv
// beam_sum_if: sampler-side and result-side signals of the delay-and-sum beam stage.
// The master drives the sample/steering inputs; the slave returns the beam result and status.
interface beam_sum_if #(
   parameter int AW = 3
);
   logic          new_sample;
   logic [7:0]    ch0, ch1, ch2, ch3;
   logic [AW-1:0] delay0, delay1, delay2, delay3;
   logic [9:0]    beam;
   logic          beam_valid;
   logic          busy;
   logic          overrun;
   modport master (
      output new_sample, ch0, ch1, ch2, ch3, delay0, delay1, delay2, delay3,
      input  beam, beam_valid, busy, overrun
   );
   modport slave (
      input  new_sample, ch0, ch1, ch2, ch3, delay0, delay1, delay2, delay3,
      output beam, beam_valid, busy, overrun
   );
endinterface

// File: rtl/beam_sum.sv
// beam_sum: four-channel delay-and-sum beamformer with per-channel circular delay lines.
// Optional macro BEAM_OFFSET_REMOVE_EN: samples are re-centred (x - 128) before summing,
// the beam becomes two's complement and delay lines reset to mid-scale 0x80.
module beam_sum #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input logic     clk,
   input logic     n_reset,
   beam_sum_if.slave bus
);
`ifdef BEAM_OFFSET_REMOVE_EN
   localparam logic [7:0] ZERO = 8'h80;
`else
   localparam logic [7:0] ZERO = 8'h00;
`endif
   typedef enum logic [1:0] {IDLE, WRITE, ACC, OUT} state_t;
   state_t        state_q, state_d;
   logic [1:0]    k_q, k_d;
   logic          ns_q;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] base_q, base_d;
   logic [AW-1:0] dly_q [4];
   logic [9:0]    acc_q, acc_d;
   logic [9:0]    beam_q, beam_d;
   logic          valid_q, valid_d;
   logic          overrun_q, overrun_d;
   logic [7:0]    mem_q [4][DEPTH];
   logic          rise;
   logic [7:0]    rd;
   logic [9:0]    rd_ext;
   assign rise = bus.new_sample & ~ns_q;
   assign rd   = mem_q[k_q][base_q - dly_q[k_q]];
`ifdef BEAM_OFFSET_REMOVE_EN
   assign rd_ext = {2'b00, rd} - 10'd128;
`else
   assign rd_ext = {2'b00, rd};
`endif
   assign bus.beam       = beam_q;
   assign bus.beam_valid = valid_q;
   assign bus.busy       = state_q != IDLE;
   assign bus.overrun    = overrun_q;
   // Next-state and datapath update; edges arriving outside IDLE are dropped and flagged
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      wr_ptr_d  = wr_ptr_q;
      base_d    = base_q;
      acc_d     = acc_q;
      beam_d    = beam_q;
      valid_d   = 1'b0;
      overrun_d = overrun_q | (rise & (state_q != IDLE));
      case (state_q)
         IDLE: state_d = rise ? WRITE : IDLE;
         WRITE: begin
            base_d   = wr_ptr_q;
            wr_ptr_d = wr_ptr_q + AW'(1);
            acc_d    = '0;
            k_d      = '0;
            state_d  = ACC;
         end
         ACC: begin
            acc_d   = acc_q + rd_ext;
            k_d     = k_q + 2'd1;
            state_d = (k_q == 2'd3) ? OUT : ACC;
         end
         OUT: begin
            beam_d  = acc_q;
            valid_d = 1'b1;
            state_d = IDLE;
         end
      endcase
   end
   // FSM and control/result registers
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q   <= IDLE;
         k_q       <= '0;
         ns_q      <= 1'b0;
         wr_ptr_q  <= '0;
         base_q    <= '0;
         acc_q     <= '0;
         beam_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         ns_q      <= bus.new_sample;
         wr_ptr_q  <= wr_ptr_d;
         base_q    <= base_d;
         acc_q     <= acc_d;
         beam_q    <= beam_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end
   // Delay lines and steering delays captured once per accepted sample
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         for (int c = 0; c < 4; c++) begin
            dly_q[c] <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[c][i] <= ZERO;
         end
      end else if (state_q == WRITE) begin
         mem_q[0][wr_ptr_q] <= bus.ch0;
         mem_q[1][wr_ptr_q] <= bus.ch1;
         mem_q[2][wr_ptr_q] <= bus.ch2;
         mem_q[3][wr_ptr_q] <= bus.ch3;
         dly_q[0]           <= bus.delay0;
         dly_q[1]           <= bus.delay1;
         dly_q[2]           <= bus.delay2;
         dly_q[3]           <= bus.delay3;
      end
   end
endmodule

// File: tb/tb_beam_sum.sv
// tb_beam_sum: directed scoreboard bench for beam_sum (default build and BEAM_OFFSET_REMOVE_EN).
module tb_beam_sum;
   logic clk = 1'b0;
   logic n_reset = 1'b0;
   always #5 clk = ~clk;
   beam_sum_if #(.AW(3)) bus();
   beam_sum #(.DEPTH(8), .AW(3)) dut (.clk(clk), .n_reset(n_reset), .bus(bus.slave));
   int n_vec = 0;
   int n_err = 0;
   logic [9:0] sb [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] chs, input logic [11:0] dls);
      {bus.ch3, bus.ch2, bus.ch1, bus.ch0} = chs;
      {bus.delay3, bus.delay2, bus.delay1, bus.delay0} = dls;
   endtask

   // call right after the negedge on which new_sample was raised
   task automatic wait_result(input string tag, input bit hold);
      int lat = 0;
      logic [9:0] e;
      do begin
         @(negedge clk);
         lat++;
         if (!hold) bus.new_sample = 1'b0;
      end while (!bus.beam_valid && lat < 20);
      if (sb.size() != 0) e = sb.pop_front();
      else e = 'x;
      chk({tag, "_lat"}, lat, 7);
      chk({tag, "_beam"}, {22'd0, bus.beam}, {22'd0, e});
      chk({tag, "_busy"}, {31'd0, bus.busy}, 0);
      @(negedge clk);
      chk({tag, "_strobe"}, {31'd0, bus.beam_valid}, 0);
   endtask

   task automatic send(input string tag, input logic [31:0] chs, input logic [11:0] dls,
                       input logic [9:0] exp, input bit hold);
      @(negedge clk);
      drive(chs, dls);
      bus.new_sample = 1'b1;
      sb.push_back(exp);
      wait_result(tag, hold);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      n_reset = 1'b0;
      @(negedge clk);
      n_reset = 1'b1;
      sb.delete();
   endtask

   initial begin
      int cnt;
      bus.new_sample = 1'b0;
      drive(32'd0, 12'd0);
      repeat (2) @(negedge clk);
      chk("rst_beam", {22'd0, bus.beam}, 0);
      chk("rst_valid", {31'd0, bus.beam_valid}, 0);
      chk("rst_busy", {31'd0, bus.busy}, 0);
      chk("rst_overrun", {31'd0, bus.overrun}, 0);
      n_reset = 1'b1;
`ifndef BEAM_OFFSET_REMOVE_EN
      send("zero", 32'h281E140A, 12'h000, 10'd100, 1'b1);
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.beam_valid) cnt++;
      end
      chk("level_no_repeat", cnt, 0);
      chk("level_overrun", {31'd0, bus.overrun}, 0);
      bus.new_sample = 1'b0;
      pulse_reset();
      send("steer_a", 32'h0A0A0A0A, 12'h001, 10'd30, 1'b0);
      send("steer_b", 32'h32323232, 12'h001, 10'd160, 1'b0);
      pulse_reset();
      for (int i = 1; i <= 10; i++)
         send($sformatf("wrap%0d", i), {8'(i), 24'h0}, {3'd7, 9'd0},
              (i < 8) ? 10'd0 : 10'(i - 7), 1'b0);
      @(negedge clk);
      drive(32'h07070707, 12'h000);
      bus.new_sample = 1'b1;
      sb.push_back(10'd28);
      @(negedge clk);
      bus.new_sample = 1'b0;
      @(negedge clk);
      @(negedge clk);
      drive(32'h63636363, 12'h000);
      bus.new_sample = 1'b1;
      @(negedge clk);
      bus.new_sample = 1'b0;
      cnt = 0;
      repeat (14) begin
         @(negedge clk);
         if (bus.beam_valid) begin
            cnt++;
            chk("ovr_beam", {22'd0, bus.beam}, (sb.size() != 0) ? {22'd0, sb.pop_front()} : 'x);
         end
      end
      chk("ovr_count", cnt, 1);
      chk("ovr_flag", {31'd0, bus.overrun}, 1);
      send("ovr_ptr", 32'h01010101, 12'h001, 10'd10, 1'b0);
      chk("ovr_sticky", {31'd0, bus.overrun}, 1);
      @(negedge clk);
      drive(32'h32323232, 12'h000);
      bus.new_sample = 1'b1;
      @(negedge clk);
      bus.new_sample = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_reset = 1'b0;
      #1;
      chk("acc_rst_beam", {22'd0, bus.beam}, 0);
      chk("acc_rst_valid", {31'd0, bus.beam_valid}, 0);
      chk("acc_rst_busy", {31'd0, bus.busy}, 0);
      chk("acc_rst_overrun", {31'd0, bus.overrun}, 0);
      @(negedge clk);
      n_reset = 1'b1;
      sb.delete();
      send("post_rst", 32'h05050505, 12'h000, 10'd20, 1'b0);
`else
      send("off_first", 32'h80808080, 12'h003, 10'd0, 1'b0);
      send("off_mid", 32'h80808080, 12'h000, 10'd0, 1'b0);
      send("off_max", 32'hFFFFFFFF, 12'h000, 10'd508, 1'b0);
      send("off_min", 32'h00000000, 12'h000, 10'h200, 1'b0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/beam_sum.md
# beam_sum

Delay-and-sum beamforming stage placed directly downstream of the four-channel ADC sampler in the phased-array microphone design. On each new sample it captures the four 8-bit channel values into per-channel circular delay lines. It then sums one delayed sample from each channel, each channel using its own steering delay, and emits one 10-bit beam sample with a one-cycle valid strobe. The output feeds the LED/display and downstream analysis logic in place of the raw channel-0 value.

## Interface
- `DEPTH`, 8: delay-line length per channel in samples; power of two, ≥2.
- `AW`, 3: delay/pointer width; must equal log2(`DEPTH`).
- `clk` in 1: system clock; the same clock as the ADC sampler.
- `n_reset` in 1: asynchronous, active-low reset.
- `new_sample` in 1: sampler's new-sample flag, synchronous to `clk`; may be a pulse or a level; only rising edges are used.
- `ch0`..`ch3` in 8 each: unsigned ADC samples; stable while `new_sample` is high.
- `delay0`..`delay3` in `AW` each: steering delay per channel in samples, range 0..`DEPTH`-1.
- `beam` out 10: delay-and-sum result, held between updates.
- `beam_valid` out 1: one-cycle strobe marking a new `beam` value.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `overrun` out 1: sticky flag, set when a sample edge is dropped; cleared only by reset.

## Operation
- Edge detect: register `ns_q` ← `new_sample`; `rise = new_sample & ~ns_q`.
- FSM states: IDLE, WRITE, ACC (2-bit index k = 0..3), OUT.
  - IDLE: `rise` → WRITE.
  - WRITE: write `chK` into `buf_K[wr_ptr]` for all K; latch `delay0..3`; save `base = wr_ptr`; `wr_ptr` ← `wr_ptr+1` mod `DEPTH`; clear `acc`; → ACC with k=0.
  - ACC: `acc += ext(buf_k[(base - delay_k) mod DEPTH])`; k=3 → OUT, otherwise k+1.
  - OUT: `beam` ← `acc`; `beam_valid` ← 1 for one cycle; → IDLE.
- Delay 0 selects the sample written in the same WRITE; delay d selects the sample written d events earlier.
- Address arithmetic is unsigned `AW`-bit modulo `DEPTH`. Wrap-around is natural, and `wr_ptr` wraps from `DEPTH`-1 to 0.
- Accumulator is 10 bits and never overflows: without the macro the maximum is 4×255 = 1020.
- A `rise` seen in any state other than IDLE is dropped: no write, no output, and `overrun` is set.
- Delay inputs changing mid-sequence have no effect, because only the latched values are used.
- Reset (asynchronous, any state), all cleared: FSM to IDLE; `ns_q`, `wr_ptr`, `acc`, `beam`, `beam_valid`, `overrun` to 0; every buffer entry to the zero-signal value (0x00, or 0x80 with the macro enabled). Output `busy` is 0.

## Timing
- T0: the `clk` edge where `rise` = 1 and state = IDLE. State becomes WRITE.
- T1: buffer write and delay latch.
- T2..T5: accumulate ch0..ch3 in that order.
- T6: `beam` updated and `beam_valid` = 1 for the cycle following T6.
- Latency is 6 edges from the detecting edge to valid. `busy` is high from after T0 through T6.
- Earliest next accepted edge is T7. A `rise` at T1..T6 is an overrun.
- Throughput: one beam sample per ≥7 clocks, far above the ADC conversion rate.

## Configuration
- `BEAM_OFFSET_REMOVE_EN` defined:
  - Each read sample is converted to signed before accumulation as `{2'b0,x} - 128`.
  - `beam` is 10-bit two's complement, range −512..508.
  - Buffers reset to 0x80.
- Undefined: samples are zero-extended, `beam` is unsigned 0..1020, and buffers reset to 0x00.

## Test plan
- Reset: assert `n_reset`=0 mid-ACC → all outputs 0 immediately. After release, first sample with all channels 0x05 and delays 0 → `beam`=20.
- Zero delay, macro off: ch0..3 = 10, 20, 30, 40 with delays 0 → `beam`=100 and `beam_valid` high exactly one cycle after edge T6. Holding `new_sample` high as a level produces no second result.
- Steering: delay0=1, others 0. Event A: all channels 10. Event B: all channels 50. → results 0+30=30, then 10+150=160.
- Wrap: delay3=7, ch3 = event index 1..10, other channels 0 → event 8 gives 1, event 9 gives 2, event 10 gives 3, across the `wr_ptr` wrap.
- Overrun: second `rise` at T3 → exactly one `beam_valid`, `overrun`=1 until reset, and `wr_ptr` advanced only once.
- Macro on, all delays 0:
  - all channels 0x80 → `beam`=0.
  - all channels 0xFF → 508.
  - all channels 0x00 → 10'h200 (−512).
  - first event after reset with delay0=3 and all channels 0x80 → 0.
